// File: rtl/sonar_pkg.sv
// Shared types, ASCII constants and helpers for the sonar range-frame parser.
package sonar_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DIGIT = 2'd1,
        TERM  = 2'd2
    } state_t;

    localparam logic [7:0] ASCII_0        = 8'h30;
    localparam logic [7:0] ASCII_9        = 8'h39;
    localparam logic [7:0] DEF_HEADER     = 8'h52;  // 'R'
    localparam logic [7:0] DEF_TERMINATOR = 8'h0D;  // CR

    function automatic logic is_digit(input logic [7:0] b);
        return (b >= ASCII_0) && (b <= ASCII_9);
    endfunction

endpackage

// File: rtl/sonar_dec_accum.sv
// One decimal accumulation step: acc*10 + digit, clamped to the DIST_W maximum.
// A saturated input always re-saturates, since max*10 already exceeds the clamp.
module sonar_dec_accum
    import sonar_pkg::*;
#(
    parameter int DIST_W = 16
) (
    input  logic [DIST_W-1:0] acc_i,
    input  logic [3:0]        digit_i,
    output logic [DIST_W-1:0] acc_o
);

    localparam int WIDE_W = DIST_W + 4;
    localparam logic [WIDE_W-1:0] SAT = {4'd0, {DIST_W{1'b1}}};

    logic [WIDE_W-1:0] wide;

    // Widen by 4 bits so acc*10+9 never overflows before the clamp.
    always_comb begin
        wide  = ({4'd0, acc_i} * WIDE_W'(10)) + {{DIST_W{1'b0}}, digit_i};
        acc_o = (wide > SAT) ? SAT[DIST_W-1:0] : wide[DIST_W-1:0];
    end

endmodule

// File: rtl/sonar_frame_parser.sv
// ASCII range-frame parser: HEADER, DIGITS decimal digits [, TERMINATOR].
// Publishes packed BCD and saturated binary distance with 1-cycle strobes.
// Optional feature macro: SONAR_TERM_CHECK_EN (require TERMINATOR after last digit).
module sonar_frame_parser
    import sonar_pkg::*;
#(
    parameter int         DIGITS         = 3,
    parameter logic [7:0] HEADER         = DEF_HEADER,
    parameter logic [7:0] TERMINATOR     = DEF_TERMINATOR,
    parameter int         DIST_W         = 16,
    parameter int         TIMEOUT_CYCLES = 500000
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [7:0]            byte_data_i,
    input  logic                  byte_ready_i,
    output logic [4*DIGITS-1:0]   bcd_o,
    output logic [DIST_W-1:0]     distance_o,
    output logic                  frame_valid_o,
    output logic                  err_format_o,
    output logic                  err_timeout_o
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    state_t                state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DIST_W-1:0]     acc_q, acc_d, acc_nx;
    logic [4*DIGITS-1:0]   shd_q, shd_d, shd_new;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [4*DIGITS-1:0]   bcd_q, bcd_d;
    logic [DIST_W-1:0]     dist_q, dist_d;
    logic                  fv_q, fv_d, ef_q, ef_d, et_q, et_d;
    logic                  last_dig;
    int                    pos;

    sonar_dec_accum #(.DIST_W(DIST_W)) u_accum (
        .acc_i   (acc_q),
        .digit_i (byte_data_i[3:0]),
        .acc_o   (acc_nx)
    );

    // Next-state: inter-byte timeout first, then byte-driven frame FSM.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        acc_d    = acc_q;
        shd_d    = shd_q;
        bcd_d    = bcd_q;
        dist_d   = dist_q;
        fv_d     = 1'b0;
        ef_d     = 1'b0;
        et_d     = 1'b0;
        cnt_d    = cnt_q;
        // Index 0 is the most significant digit, kept in the top nibble.
        pos      = (DIGITS - 1 - int'(idx_q)) * 4;
        shd_new  = shd_q;
        shd_new[pos +: 4] = byte_data_i[3:0];
        last_dig = (idx_q == IDX_W'(DIGITS - 1));

        if (state_q == IDLE || byte_ready_i) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            // A byte on the expiry cycle takes the branch above instead.
            cnt_d   = '0;
            et_d    = 1'b1;
            state_d = IDLE;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end

        if (byte_ready_i) begin
            case (state_q)
                IDLE: begin
                    if (byte_data_i == HEADER) begin
                        state_d = DIGIT;
                        idx_d   = '0;
                        acc_d   = '0;
                    end
                end
                DIGIT: begin
                    if (is_digit(byte_data_i)) begin
                        shd_d = shd_new;
                        acc_d = acc_nx;
                        if (last_dig) begin
`ifdef SONAR_TERM_CHECK_EN
                            state_d = TERM;
`else
                            bcd_d   = shd_new;
                            dist_d  = acc_nx;
                            fv_d    = 1'b1;
                            state_d = IDLE;
`endif
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end else if (byte_data_i == HEADER) begin
                        ef_d  = 1'b1;
                        idx_d = '0;
                        acc_d = '0;
                    end else begin
                        ef_d    = 1'b1;
                        state_d = IDLE;
                    end
                end
`ifdef SONAR_TERM_CHECK_EN
                TERM: begin
                    if (byte_data_i == TERMINATOR) begin
                        bcd_d   = shd_q;
                        dist_d  = acc_q;
                        fv_d    = 1'b1;
                        state_d = IDLE;
                    end else if (byte_data_i == HEADER) begin
                        ef_d    = 1'b1;
                        state_d = DIGIT;
                        idx_d   = '0;
                        acc_d   = '0;
                    end else begin
                        ef_d    = 1'b1;
                        state_d = IDLE;
                    end
                end
`endif
                default: state_d = IDLE;
            endcase
        end
    end

    // State and output registers; async reset discards any partial frame.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            idx_q   <= '0;
            acc_q   <= '0;
            shd_q   <= '0;
            cnt_q   <= '0;
            bcd_q   <= '0;
            dist_q  <= '0;
            fv_q    <= 1'b0;
            ef_q    <= 1'b0;
            et_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            shd_q   <= shd_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
            dist_q  <= dist_d;
            fv_q    <= fv_d;
            ef_q    <= ef_d;
            et_q    <= et_d;
        end
    end

    assign bcd_o         = bcd_q;
    assign distance_o    = dist_q;
    assign frame_valid_o = fv_q;
    assign err_format_o  = ef_q;
    assign err_timeout_o = et_q;

endmodule
